image_brightness_ctrl: RTL and testbench

IMAGE_BRIGHTNESS_CTRL -- requirements
Module: image_brightness_ctrl

---
 rtl/image_brightness_ctrl.sv | 150 +++++++++++++++
 tb/tb_image_brightness_ctrl.sv | 209 ++++++++++++++++++++
 2 files changed

// File: rtl/image_brightness_ctrl.sv
// Frame-sequenced brightness adjuster: reads each pixel of a row-major image,
// adds or subtracts a per-frame offset with clamping, and hands the result
// downstream over a valid/ready handshake.
module image_brightness_ctrl #(
  parameter int HEIGHT = 768,
  parameter int WIDTH  = 512,
  parameter int ADDR_W = 19
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              abort,
  input  logic [7:0]        v,
  input  logic              dir,
  output logic              rd_en,
  output logic [ADDR_W-1:0] rd_addr,
  input  logic [7:0]        R_in,
  input  logic [7:0]        G_in,
  input  logic [7:0]        B_in,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [7:0]        R,
  output logic [7:0]        G,
  output logic [7:0]        B,
  output logic              out_last,
  output logic              busy,
  output logic              done
);

  localparam int DATA_W = 8;
  localparam int NPIX   = HEIGHT * WIDTH;
  localparam logic [ADDR_W-1:0] LAST_PIX = ADDR_W'(NPIX - 1);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_READ = 3'd1,
    S_LOAD = 3'd2,
    S_SEND = 3'd3,
    S_DONE = 3'd4
  } state_t;

  state_t state, state_nxt;

  logic [ADDR_W-1:0] cnt;
  logic [DATA_W-1:0] v_lat;
  logic              dir_lat;
  logic              last_pix;
  logic              hs;

  // Add with a 9-bit intermediate so the carry selects the 255 clamp.
  function automatic logic [DATA_W-1:0] sat_add(input logic [DATA_W-1:0] a,
                                                input logic [DATA_W-1:0] b);
    logic [DATA_W:0] s;
    s = {1'b0, a} + {1'b0, b};
    return s[DATA_W] ? {DATA_W{1'b1}} : s[DATA_W-1:0];
  endfunction

  // Subtract with a floor at zero; equal operands also give zero.
  function automatic logic [DATA_W-1:0] floor_sub(input logic [DATA_W-1:0] a,
                                                  input logic [DATA_W-1:0] b);
    return (a > b) ? (a - b) : '0;
  endfunction

  function automatic logic [DATA_W-1:0] adjust(input logic [DATA_W-1:0] px,
                                               input logic [DATA_W-1:0] off,
                                               input logic              up);
    return up ? sat_add(px, off) : floor_sub(px, off);
  endfunction

  assign last_pix = (cnt == LAST_PIX);
  assign hs       = (state == S_SEND) && out_ready && !abort;

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_nxt;
  end

  // Next-state logic; abort outranks the SEND handshake, start outranks abort in IDLE.
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE: if (start) state_nxt = S_READ;
      S_READ: state_nxt = abort ? S_IDLE : S_LOAD;
      S_LOAD: state_nxt = abort ? S_IDLE : S_SEND;
      S_SEND: begin
        if (abort)          state_nxt = S_IDLE;
        else if (out_ready) state_nxt = last_pix ? S_DONE : S_READ;
      end
      S_DONE: state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  // Outputs decoded directly from state so reset clears them without a clock.
  always_comb begin
    rd_en     = 1'b0;
    out_valid = 1'b0;
    out_last  = 1'b0;
    busy      = 1'b0;
    done      = 1'b0;
    case (state)
      S_READ: begin
        rd_en = 1'b1;
        busy  = 1'b1;
      end
      S_LOAD: busy = 1'b1;
      S_SEND: begin
        out_valid = 1'b1;
        out_last  = last_pix;
        busy      = 1'b1;
      end
      S_DONE: done = 1'b1;
      default: ;
    endcase
  end

  assign rd_addr = cnt;

  // Frame setup: latch offset/direction and pixel counter handling.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt     <= '0;
      v_lat   <= '0;
      dir_lat <= 1'b0;
    end else begin
      if (state == S_IDLE && start) begin
        cnt     <= '0;
        v_lat   <= v;
        dir_lat <= dir;
      end else if (hs && !last_pix) begin
        cnt <= cnt + ADDR_W'(1);
      end
    end
  end

  // --- stage boundary: memory data -> adjusted pixel register ---
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      R <= '0;
      G <= '0;
      B <= '0;
    end else if (state == S_LOAD) begin
      R <= adjust(R_in, v_lat, dir_lat);
      G <= adjust(G_in, v_lat, dir_lat);
      B <= adjust(B_in, v_lat, dir_lat);
    end
  end

endmodule

// File: tb/tb_image_brightness_ctrl.sv
// Directed bench for image_brightness_ctrl on a 2x2 frame.
module tb_image_brightness_ctrl;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       start = 1'b0;
  logic       abort = 1'b0;
  logic [7:0] v = 8'd0;
  logic       dir = 1'b0;
  logic       rd_en;
  logic [1:0] rd_addr;
  logic [7:0] R_in = 8'd0, G_in = 8'd0, B_in = 8'd0;
  logic       out_valid;
  logic       out_ready = 1'b1;
  logic [7:0] R, G, B;
  logic       out_last, busy, done;

  int n_vec = 0;
  int n_err = 0;

  logic [23:0] mem    [4];
  logic [23:0] exp_px [4];
  logic        rd_q = 1'b0;
  logic [1:0]  a_q  = 2'd0;

  image_brightness_ctrl #(.HEIGHT(2), .WIDTH(2), .ADDR_W(2)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .abort(abort), .v(v), .dir(dir),
    .rd_en(rd_en), .rd_addr(rd_addr), .R_in(R_in), .G_in(G_in), .B_in(B_in),
    .out_valid(out_valid), .out_ready(out_ready), .R(R), .G(G), .B(B),
    .out_last(out_last), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  // Pixel memory: data appears one cycle after the read strobe, junk otherwise.
  always @(negedge clk) begin
    rd_q = rd_en;
    a_q  = rd_addr;
  end
  always @(posedge clk) begin
    #1;
    if (rd_q) {R_in, G_in, B_in} = mem[a_q];
    else      {R_in, G_in, B_in} = 24'hEEEEEE;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_vec++;
    if (obs !== expv) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", tag, obs, expv);
    end
  endtask

  task automatic load_set1();
    mem[0] = {8'd100, 8'd50, 8'd10};  exp_px[0] = {8'd50,  8'd0, 8'd0};
    mem[1] = {8'd255, 8'd0,  8'd51};  exp_px[1] = {8'd205, 8'd0, 8'd1};
    mem[2] = {8'd49,  8'd50, 8'd200}; exp_px[2] = {8'd0,   8'd0, 8'd150};
    mem[3] = {8'd0,   8'd0,  8'd0};   exp_px[3] = {8'd0,   8'd0, 8'd0};
  endtask

  task automatic load_set2();
    mem[0] = {8'd55,  8'd56,  8'd255}; exp_px[0] = {8'd255, 8'd255, 8'd255};
    mem[1] = {8'd10,  8'd0,   8'd54};  exp_px[1] = {8'd210, 8'd200, 8'd254};
    mem[2] = {8'd0,   8'd0,   8'd0};   exp_px[2] = {8'd200, 8'd200, 8'd200};
    mem[3] = {8'd255, 8'd255, 8'd255}; exp_px[3] = {8'd255, 8'd255, 8'd255};
  endtask

  // Run one full frame from IDLE; cycle numbering counts the start edge as 1.
  task automatic run_frame(input int stall_at, input bit poke, input bit with_abort,
                           input int exp_cyc);
    int cyc;
    int pix;
    bit fin;
    logic [23:0] held;
    pix = 0;
    fin = 1'b0;
    @(negedge clk);
    start = 1'b1;
    abort = with_abort;
    @(posedge clk);
    cyc = 1;
    while (!fin && cyc < 100) begin
      @(negedge clk);
      start = (poke && cyc == 4);
      abort = 1'b0;
      if (poke && cyc == 4) begin
        v   = 8'd0;
        dir = ~dir;
      end
      if (rd_en) chk("rd_addr", 32'(rd_addr), 32'(pix));
      if (out_valid) begin
        if (pix == stall_at) begin
          out_ready = 1'b0;
          held = {R, G, B};
          for (int k = 0; k < 5; k++) begin
            @(posedge clk);
            cyc++;
            @(negedge clk);
            chk("stall_valid", 32'(out_valid), 32'd1);
            chk("stall_rgb", 32'({R, G, B}), 32'(held));
            chk("stall_rd_en", 32'(rd_en), 32'd0);
            chk("stall_addr", 32'(rd_addr), 32'(pix));
          end
          out_ready = 1'b1;
        end
        chk("rgb", 32'({R, G, B}), 32'(exp_px[pix]));
        chk("out_last", 32'(out_last), 32'(pix == 3));
        pix++;
      end else begin
        chk("out_last_idle", 32'(out_last), 32'd0);
      end
      if (done) begin
        fin = 1'b1;
        chk("done_cycle", 32'(cyc), 32'(exp_cyc));
      end
      @(posedge clk);
      cyc++;
    end
    if (!fin) chk("done_timeout", 32'd0, 32'd1);
    chk("pixel_count", 32'(pix), 32'd4);
    @(negedge clk);
    chk("done_width", 32'(done), 32'd0);
    chk("busy_after", 32'(busy), 32'd0);
  endtask

  initial begin
    bit found;
    // Reset state
    #3;
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_valid", 32'(out_valid), 32'd0);
    chk("rst_rd_en", 32'(rd_en), 32'd0);
    chk("rst_addr", 32'(rd_addr), 32'd0);
    chk("rst_rgb", 32'({R, G, B}), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // Decrease frame; offset/dir change plus start while busy must not matter
    load_set1();
    v = 8'd50; dir = 1'b0;
    run_frame(-1, 1'b1, 1'b0, 13);

    // Abort in SEND of pixel 1
    v = 8'd50; dir = 1'b0;
    @(negedge clk);
    start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    found = 1'b0;
    for (int i = 0; i < 40 && !found; i++) begin
      if (out_valid && rd_addr == 2'd1) found = 1'b1;
      else @(negedge clk);
    end
    chk("abort_reach", 32'(found), 32'd1);
    abort = 1'b1;
    @(posedge clk);
    @(negedge clk);
    abort = 1'b0;
    chk("abort_valid", 32'(out_valid), 32'd0);
    chk("abort_busy", 32'(busy), 32'd0);
    chk("abort_done", 32'(done), 32'd0);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("abort_idle_done", 32'(done), 32'd0);
      chk("abort_idle_busy", 32'(busy), 32'd0);
    end
    // Restart with start and abort together: start wins, frame re-reads from 0
    run_frame(-1, 1'b0, 1'b1, 13);

    // Increase frame with saturation and a 5-cycle stall on pixel 1
    load_set2();
    v = 8'd200; dir = 1'b1;
    run_frame(1, 1'b0, 1'b0, 18);

    // Asynchronous reset in LOAD
    v = 8'd50; dir = 1'b0;
    @(negedge clk);
    start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    chk("pre_rst_rd_en", 32'(rd_en), 32'd1);
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst_busy", 32'(busy), 32'd0);
    chk("arst_rd_en", 32'(rd_en), 32'd0);
    chk("arst_valid", 32'(out_valid), 32'd0);
    chk("arst_last", 32'(out_last), 32'd0);
    chk("arst_done", 32'(done), 32'd0);
    chk("arst_addr", 32'(rd_addr), 32'd0);
    chk("arst_rgb", 32'({R, G, B}), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("post_rst_busy", 32'(busy), 32'd0);
      chk("post_rst_rd_en", 32'(rd_en), 32'd0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
